// File: rtl/srrc_tx_sym_sched.sv
// Transmit symbol scheduler for the 4-ary PAM SRRC chain: derives sample/symbol
// strobes, accepts Gray-coded symbols and sequences start, run and filter drain.
module srrc_tx_sym_sched #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SPS           = 4,
  parameter int unsigned FLT_SPAN_SYMS = 29
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  sym_in,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic [17:0] sym_out,
  output logic        sam_clk_en,
  output logic        sym_clk_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] underrun_cnt
);

  localparam int unsigned CLK_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SAM_CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int unsigned DRAIN_W   = (FLT_SPAN_SYMS > 1) ? $clog2(FLT_SPAN_SYMS) : 1;

  // Level codes in the filter's signed 18-bit input format (+-0.25, +-0.75)
  localparam logic [17:0] SYMBOL_N2 = 18'h28000;
  localparam logic [17:0] SYMBOL_N1 = 18'h38000;
  localparam logic [17:0] SYMBOL_P1 = 18'h08000;
  localparam logic [17:0] SYMBOL_P2 = 18'h18000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [CLK_CNT_W-1:0] clk_cnt;
  logic [SAM_CNT_W-1:0] sam_cnt;
  logic                 clk_wrap, sam_wrap;
  logic                 start_pend, start_pend_d;
  logic                 stop_pend, stop_pend_d;
  logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_d;
  logic [17:0]          sym_out_d;
  logic                 busy_d, done_d;
  logic [15:0]          underrun_d;

  function automatic logic [17:0] map_sym(input logic [1:0] s);
    case (s)
      2'b00:   map_sym = SYMBOL_N2;
      2'b01:   map_sym = SYMBOL_N1;
      2'b11:   map_sym = SYMBOL_P1;
      default: map_sym = SYMBOL_P2;
    endcase
  endfunction

  assign clk_wrap = (clk_cnt == CLK_CNT_W'(CLK_DIV - 1));
  assign sam_wrap = (sam_cnt == SAM_CNT_W'(SPS - 1));

  // Free-running strobe generator, independent of the transmit state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt    <= '0;
      sam_cnt    <= '0;
      sam_clk_en <= 1'b0;
      sym_clk_en <= 1'b0;
    end else begin
      clk_cnt    <= clk_wrap ? '0 : clk_cnt + CLK_CNT_W'(1);
      sam_clk_en <= clk_wrap;
      sym_clk_en <= clk_wrap && sam_wrap;
      if (clk_wrap) begin
        sam_cnt <= sam_wrap ? '0 : sam_cnt + SAM_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      start_pend   <= 1'b0;
      stop_pend    <= 1'b0;
      drain_cnt    <= '0;
      sym_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state        <= state_d;
      start_pend   <= start_pend_d;
      stop_pend    <= stop_pend_d;
      drain_cnt    <= drain_cnt_d;
      sym_out      <= sym_out_d;
      busy         <= busy_d;
      done         <= done_d;
      underrun_cnt <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state;
    start_pend_d = start_pend;
    stop_pend_d  = stop_pend;
    drain_cnt_d  = drain_cnt;
    sym_out_d    = sym_out;
    underrun_d   = underrun_cnt;
    done_d       = 1'b0;
    sym_ready    = 1'b0;

    if (sym_clk_en) begin
      start_pend_d = 1'b0;
      stop_pend_d  = 1'b0;
      case (state)
        ST_IDLE: begin
          sym_out_d = '0;
          if (start_pend && !stop_pend) begin
            state_d   = ST_RUN;
            sym_ready = 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_pend) begin
            state_d     = ST_DRAIN;
            sym_out_d   = '0;
            drain_cnt_d = DRAIN_W'(FLT_SPAN_SYMS - 1);
          end else begin
            sym_ready = 1'b1;
          end
        end
        ST_DRAIN: begin
          sym_out_d = '0;
          if (drain_cnt == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt - DRAIN_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Every acceptance slot either carries a symbol or is zero-stuffed
      if (sym_ready) begin
        if (sym_valid) begin
          sym_out_d = map_sym(sym_in);
        end else begin
          sym_out_d = '0;
          if (underrun_cnt != 16'hFFFF) begin
            underrun_d = underrun_cnt + 16'd1;
          end
        end
      end
    end

    // A request arriving on a strobe cycle is held for the following strobe
    if (start && (state == ST_IDLE)) begin
      start_pend_d = 1'b1;
    end
    if (stop) begin
      stop_pend_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_srrc_tx_sym_sched.sv
// Scoreboard bench for srrc_tx_sym_sched: a slot-level reference model queues the
// expected outcome of each symbol strobe; a negedge monitor checks every cycle.
module tb_srrc_tx_sym_sched;

  localparam int CLK_DIV = 4;
  localparam int SPS     = 4;
  localparam int FLT     = 29;
  localparam int PER     = CLK_DIV * SPS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  sym_in = 2'b00;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [17:0] sym_out;
  logic        sam_clk_en;
  logic        sym_clk_en;
  logic        busy;
  logic        done;
  logic [15:0] underrun_cnt;

  srrc_tx_sym_sched #(
    .CLK_DIV      (CLK_DIV),
    .SPS          (SPS),
    .FLT_SPAN_SYMS(FLT)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .start       (start),
    .stop        (stop),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_out     (sym_out),
    .sam_clk_en  (sam_clk_en),
    .sym_clk_en  (sym_clk_en),
    .busy        (busy),
    .done        (done),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ready;
    logic [17:0] out;
    bit          busy;
    bit          done;
    int          uc;
  } slot_t;

  slot_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = -1;

  // Slot-level reference model state
  int m_mode = 0;        // 0 idle, 1 transmitting, 2 flushing filter
  int m_drain_end = 0;
  int slot_idx = 0;
  int m_uc = 0;
  bit m_start = 0;
  bit m_stop = 0;
  bit hold = 0;

  // Monitor-side expectations for the current symbol period
  logic [17:0] exp_out = '0;
  bit          exp_busy = 0;
  bit          exp_done = 0;
  int          exp_uc = 0;
  slot_t       mon_rec;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Gray code -> level index -> evenly spaced levels -3,-1,+1,+3 times 2^15
  function automatic logic [17:0] level_of(input logic [1:0] g);
    int k;
    k = 2 * int'(g[1]) + int'(g[1] ^ g[0]);
    return 18'((2 * k - 3) * 32768);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_out  = '0;
      exp_busy = 0;
      exp_done = 0;
      exp_uc   = 0;
      check("rst_sam_clk_en", longint'(sam_clk_en), 0);
      check("rst_sym_clk_en", longint'(sym_clk_en), 0);
      check("rst_sym_ready", longint'(sym_ready), 0);
      check("rst_sym_out", longint'(sym_out), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_underrun_cnt", longint'(underrun_cnt), 0);
    end else begin
      check("sam_clk_en", longint'(sam_clk_en), longint'((cyc % CLK_DIV) == CLK_DIV - 1));
      check("sym_clk_en", longint'(sym_clk_en), longint'((cyc % PER) == PER - 1));
      check("sym_out", longint'(sym_out), longint'(exp_out));
      check("busy", longint'(busy), longint'(exp_busy));
      check("done", longint'(done), longint'(exp_done));
      check("underrun_cnt", longint'(underrun_cnt), longint'(exp_uc));
      exp_done = 0;
      if (sym_clk_en) begin
        if (exp_q.size() == 0) begin
          check("slot_expected", 0, 1);
        end else begin
          mon_rec = exp_q.pop_front();
          check("sym_ready_slot", longint'(sym_ready), longint'(mon_rec.ready));
          exp_out  = mon_rec.out;
          exp_busy = mon_rec.busy;
          exp_done = mon_rec.done;
          exp_uc   = mon_rec.uc;
        end
      end else begin
        check("sym_ready_idle", longint'(sym_ready), 0);
      end
    end
  end

  // One symbol period of stimulus; offsets are cycle positions 0..PER-2 or -1 for none.
  // vmode: 0 no data, 1 data, 2 random. sym_sel < 0 picks a random symbol.
  task automatic run_period(input int start_off, input int stop_off, input int vmode,
                            input int sym_sel);
    slot_t rec;
    bit    acc;
    for (int p = 0; p < PER; p++) begin
      @(posedge clk);
      #1;
      if (p == 0 && !hold) begin
        case (vmode)
          0:       sym_valid = 1'b0;
          1:       sym_valid = 1'b1;
          default: sym_valid = ($urandom_range(99) < 70);
        endcase
        sym_in = (sym_sel >= 0) ? 2'(sym_sel) : 2'($urandom_range(3));
      end
      start = (p == start_off);
      stop  = (p == stop_off);
      if (start && m_mode == 0) m_start = 1;
      if (stop) m_stop = 1;
      if (p == PER - 1) begin
        rec = '{ready: 0, out: '0, busy: 0, done: 0, uc: 0};
        acc = 0;
        case (m_mode)
          0: if (!m_stop && m_start) begin
            m_mode = 1;
            rec.ready = 1;
          end
          1: if (m_stop) begin
            m_mode = 2;
            m_drain_end = slot_idx + FLT;
          end else begin
            rec.ready = 1;
          end
          default: if (slot_idx == m_drain_end) begin
            m_mode = 0;
            rec.done = 1;
          end
        endcase
        if (rec.ready) begin
          if (sym_valid) begin
            rec.out = level_of(sym_in);
            acc = 1;
          end else if (m_uc < 65535) begin
            m_uc++;
          end
        end
        rec.uc   = m_uc;
        rec.busy = (m_mode != 0);
        m_start  = 0;
        m_stop   = 0;
        slot_idx++;
        exp_q.push_back(rec);
        hold = sym_valid && !acc;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    sym_valid = 1'b0;
    sym_in = 2'b00;
    exp_q.delete();
    m_mode = 0;
    m_uc = 0;
    m_start = 0;
    m_stop = 0;
    hold = 0;
    slot_idx = 0;
    #1;
    check("async_rst_sym_out", longint'(sym_out), 0);
    check("async_rst_busy", longint'(busy), 0);
    check("async_rst_done", longint'(done), 0);
    check("async_rst_sam_clk_en", longint'(sam_clk_en), 0);
    check("async_rst_sym_clk_en", longint'(sym_clk_en), 0);
    check("async_rst_underrun_cnt", longint'(underrun_cnt), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // start at cycle 2, symbols 00, 01, 11, 10
    run_period(2, -1, 1, 0);
    run_period(-1, -1, 1, 1);
    run_period(-1, -1, 1, 3);
    run_period(-1, -1, 1, 2);
    // three empty slots, then data resumes
    repeat (3) run_period(-1, -1, 0, -1);
    run_period(-1, -1, 1, -1);
    repeat (20) run_period(-1, -1, 2, -1);
    // stop and full drain
    run_period(-1, int'($urandom_range(14)), 2, -1);
    repeat (FLT + 2) run_period(-1, -1, 2, -1);
    // start and stop together in idle, in both orders
    run_period(3, 9, 2, -1);
    run_period(-1, -1, 2, -1);
    run_period(10, 4, 2, -1);
    run_period(-1, -1, 2, -1);
    // start during drain is ignored
    run_period(5, -1, 2, -1);
    repeat (4) run_period(-1, -1, 2, -1);
    run_period(-1, 7, 2, -1);
    run_period(2, -1, 2, -1);
    repeat (FLT + 1) run_period(-1, -1, 2, -1);
    // reset five symbols into drain
    run_period(1, -1, 1, -1);
    repeat (3) run_period(-1, -1, 2, -1);
    run_period(-1, 6, 2, -1);
    repeat (5) run_period(-1, -1, 2, -1);
    do_reset();
    repeat (3) run_period(-1, -1, 2, -1);
    // random sessions
    repeat (3) begin
      run_period(int'($urandom_range(14)), -1, 2, -1);
      repeat ($urandom_range(8, 2)) run_period(-1, -1, 2, -1);
      run_period(-1, int'($urandom_range(14)), 2, -1);
      repeat (FLT + 1) run_period(-1, -1, 2, -1);
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
